// File: rtl/ram_pkg.sv
// +--------------------------------------------------------------------------+
// | ram_pkg: shared state encoding and pointer sizing for ram_ctrl            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Words needed to hold one address: ceil(aw / dw).
  function automatic int calc_ptr_bytes(input int aw, input int dw);
    return (aw + dw - 1) / dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_core.sv
// +--------------------------------------------------------------------------+
// | ram_core: single-port synchronous RAM, read data registered, no reset     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ram_core #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:LENGTH-1];

  // rdata holds its last value on writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_ctrl.sv
// +--------------------------------------------------------------------------+
// | ram_ctrl: valid/ready RAM controller, direct and indirect addressing      |
// | Indirect mode compiled only with RAM_INDIRECT_EN. Revision: 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module ram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_ind,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [ADDR_WIDTH:0] LEN_C = (ADDR_WIDTH + 1)'(LENGTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < LEN_C);
  endfunction

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  ind_q, ind_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rd_ok_q, rd_ok_d;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  access_bad;

`ifdef RAM_INDIRECT_EN
  localparam int PTR_BYTES = calc_ptr_bytes(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W     = (PTR_BYTES > 1) ? $clog2(PTR_BYTES) : 1;
  localparam int PTR_LO_W  = (PTR_BYTES > 1) ? (PTR_BYTES - 1) * DATA_WIDTH : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_LO_W-1:0]   ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ptr_addr;
  logic [ADDR_WIDTH-1:0] byte_addr;

  // The top pointer byte comes straight from the RAM output in ACCESS.
  if (PTR_BYTES > 1) begin : g_ptr_multi
    assign ptr_addr = ADDR_WIDTH'({core_rdata, ptr_q});
  end else begin : g_ptr_single
    assign ptr_addr = ADDR_WIDTH'(core_rdata);
  end

  assign byte_addr  = addr_q + ADDR_WIDTH'(cnt_q);
  assign eff_addr   = ind_q ? ptr_addr : addr_q;
  assign access_bad = err_q || !in_range(eff_addr);
`else
  assign eff_addr   = addr_q;
  assign access_bad = ind_q || !in_range(addr_q);
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? core_rdata : '0;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    ind_d       = ind_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_ok_d     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
`ifdef RAM_INDIRECT_EN
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          ind_d   = req_ind;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef RAM_INDIRECT_EN
          cnt_d   = '0;
          ptr_d   = '0;
          err_d   = 1'b0;
          state_d = req_ind ? PTR : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
`ifdef RAM_INDIRECT_EN
      PTR: begin
        mem_addr = byte_addr;
        if (in_range(byte_addr)) begin
          mem_en = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        // Byte read on the previous edge lands in its slot now.
        for (int b = 0; b < PTR_BYTES - 1; b++) begin
          if (int'(cnt_q) == b + 1) begin
            ptr_d[b*DATA_WIDTH +: DATA_WIDTH] = core_rdata;
          end
        end
        if (int'(cnt_q) == PTR_BYTES - 1) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ACCESS: begin
        mem_addr    = eff_addr;
        mem_en      = !access_bad;
        mem_we      = !access_bad && we_q;
        rsp_valid_d = 1'b1;
        rsp_err_d   = access_bad;
        rd_ok_d     = !access_bad && !we_q;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      ind_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
`ifdef RAM_INDIRECT_EN
      cnt_q       <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      ind_q       <= ind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
`ifdef RAM_INDIRECT_EN
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
`endif
    end
  end

  ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LENGTH     (LENGTH)
  ) u_core (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (core_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_ram_ctrl: directed self-checking bench for ram_ctrl                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ram_ctrl;

  localparam int AW = 13;
  localparam int DW = 8;
`ifdef RAM_INDIRECT_EN
  localparam int IND_LAT = 4;
`else
  localparam int IND_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic          req_ind   [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_err   [2];

  int n_checks = 0;
  int n_errors = 0;

  ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(8192)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_ind(req_ind[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(6000)) u_len (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_ind(req_ind[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // lat counts edges from the accept edge (inclusive) to the response sample.
  task automatic do_req(input int s, input logic we, input logic ind,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_ind[s]   = ind;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[s]) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[s]) begin
        lat = k + 1;
        rd  = rsp_rdata[s];
        er  = rsp_err[s];
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      chk("pulse_one_cycle", rsp_valid[s], 1'b0);
    end
  endtask

  task automatic wr(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] rd;
    logic er;
    int lat;
    do_req(s, 1'b1, 1'b0, a, d, rd, er, lat);
    chk("setup_wr_err", er, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    int            acc;
    int            nrsp;
    logic          acc_next;

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_ind[s]   = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
    end

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready[0], 1'b1);
    chk("rst_valid", rsp_valid[0], 1'b0);
    chk("rst_rdata", rsp_rdata[0], 8'h00);
    chk("rst_err",   rsp_err[0],   1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Direct write then read.
    do_req(0, 1'b1, 1'b0, 13'h0100, 8'hA5, rd, er, lat);
    chk("dwr_err", er, 1'b0);
    chk("dwr_rdata", rd, 8'h00);
    chk("dwr_lat", lat, 2);
    do_req(0, 1'b0, 1'b0, 13'h0100, 8'h00, rd, er, lat);
    chk("drd_rdata", rd, 8'hA5);
    chk("drd_err", er, 1'b0);
    chk("drd_lat", lat, 2);

    // Indirect read through pointer 0x1234.
    wr(0, 13'h0010, 8'h34);
    wr(0, 13'h0011, 8'h12);
    wr(0, 13'h1234, 8'h5C);
    do_req(0, 1'b0, 1'b1, 13'h0010, 8'h00, rd, er, lat);
`ifdef RAM_INDIRECT_EN
    chk("ind_rdata", rd, 8'h5C);
    chk("ind_err", er, 1'b0);
`else
    chk("ind_rdata", rd, 8'h00);
    chk("ind_err", er, 1'b1);
`endif
    chk("ind_lat", lat, IND_LAT);

    // Indirect write through the same pointer; disabled build must not touch memory.
    do_req(0, 1'b1, 1'b1, 13'h0010, 8'h6B, rd, er, lat);
    do_req(0, 1'b0, 1'b0, 13'h1234, 8'h00, rd, er, lat);
`ifdef RAM_INDIRECT_EN
    chk("indwr_mem", rd, 8'h6B);
`else
    chk("indwr_mem", rd, 8'h5C);
`endif

    // Pointer fetch wraps from 0x1FFF to 0x0000.
    wr(0, 13'h1FFF, 8'h22);
    wr(0, 13'h0000, 8'h01);
    wr(0, 13'h0122, 8'h99);
    do_req(0, 1'b0, 1'b1, 13'h1FFF, 8'h00, rd, er, lat);
`ifdef RAM_INDIRECT_EN
    chk("wrap_rdata", rd, 8'h99);
    chk("wrap_err", er, 1'b0);
`else
    chk("wrap_rdata", rd, 8'h00);
    chk("wrap_err", er, 1'b1);
`endif

    // Second request held while busy.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_ind[0]   = 1'b0;
    req_addr[0]  = 13'h0200;
    req_wdata[0] = 8'h3C;
    @(posedge clk);
    #1;
    req_we[0] = 1'b0;
    chk("busy_ready_low", req_ready[0], 1'b0);
    acc = -1;
    nrsp = 0;
    acc_next = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (acc_next) begin
        acc = n;
        req_valid[0] = 1'b0;
        acc_next = 1'b0;
      end
      if (rsp_valid[0]) begin
        if (nrsp == 0) begin
          chk("busy_a_edge", n, 1);
          chk("busy_a_err", rsp_err[0], 1'b0);
        end else begin
          chk("busy_b_edge", n, 4);
          chk("busy_b_rdata", rsp_rdata[0], 8'h3C);
        end
        nrsp++;
      end
      if (req_valid[0] && req_ready[0]) acc_next = 1'b1;
    end
    req_valid[0] = 1'b0;
    chk("busy_b_accept", acc, 3);
    chk("busy_rsp_count", nrsp, 2);

    // Range checks with LENGTH = 6000.
    do_req(1, 1'b1, 1'b0, 13'd6000, 8'h77, rd, er, lat);
    chk("rng_wr_err", er, 1'b1);
    chk("rng_wr_lat", lat, 2);
    do_req(1, 1'b0, 1'b0, 13'd6000, 8'h00, rd, er, lat);
    chk("rng_rd_err", er, 1'b1);
    chk("rng_rd_rdata", rd, 8'h00);
    wr(1, 13'd5999, 8'h42);
    do_req(1, 1'b0, 1'b0, 13'd5999, 8'h00, rd, er, lat);
    chk("rng_last_rdata", rd, 8'h42);
    chk("rng_last_err", er, 1'b0);
    wr(1, 13'h0020, 8'hFF);
    wr(1, 13'h0021, 8'h1F);
    do_req(1, 1'b0, 1'b1, 13'h0020, 8'h00, rd, er, lat);
    chk("rng_ptr_err", er, 1'b1);
    chk("rng_ptr_rdata", rd, 8'h00);
    chk("rng_ptr_lat", lat, IND_LAT);
    do_req(1, 1'b0, 1'b1, 13'd5999, 8'h00, rd, er, lat);
    chk("rng_pbyte_err", er, 1'b1);

    // Reset during a read response clears outputs at once.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_ind[0]   = 1'b0;
    req_addr[0]  = 13'h0100;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_rdata", rsp_rdata[0], 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready[0], 1'b1);
    chk("mid_rst_valid", rsp_valid[0], 1'b0);
    chk("mid_rst_rdata", rsp_rdata[0], 8'h00);
    chk("mid_rst_err",   rsp_err[0],   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset before the write edge drops the write.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 13'h0100;
    req_wdata[0] = 8'h55;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 1'b0, 13'h0100, 8'h00, rd, er, lat);
    chk("rst_drop_wr", rd, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
